// File: rtl/memory_stage_if.sv
// Data-cache request/response bus between the memory stage (master) and the data cache (slave).
interface memory_stage_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/memory_stage.sv
// MIPS memory stage: issues data-cache accesses, holds them until dhit, selects the
// writeback value and owns the memory-writeback latch and the sticky system halt.
module memory_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        mw_state,
    input  logic              m_dREN,
    input  logic              m_dWEN,
    input  logic              m_RegWrite,
    input  logic              m_halt,
    input  logic [1:0]        m_MemToReg,
    input  logic [REG_W-1:0]  m_regWSEL,
    input  logic [WORD_W-1:0] m_port_o,
    input  logic [WORD_W-1:0] m_memstore,
    input  logic [WORD_W-1:0] m_pc4,
    input  logic [WORD_W-1:0] m_lui,
    memory_stage_if.master    dcache,
    output logic              mem_stall,
    output logic [WORD_W-1:0] m_fwd_dat,
    output logic              w_RegWrite,
    output logic [REG_W-1:0]  w_regWSEL,
    output logic [WORD_W-1:0] w_wdat,
    output logic              w_halt,
    output logic              halt
);

    localparam logic [1:0] PIPE_ENABLE = 2'd0;
    localparam logic [1:0] PIPE_STALL  = 2'd1;
    localparam logic [1:0] PIPE_NOP    = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HELD   = 2'd2
    } acc_state_t;

    acc_state_t        state_q, state_d;
    logic [WORD_W-1:0] ld_q, ld_d;
    logic              w_regwrite_q, w_regwrite_d;
    logic [REG_W-1:0]  w_regwsel_q, w_regwsel_d;
    logic [WORD_W-1:0] w_wdat_q, w_wdat_d;
    logic              w_halt_q, w_halt_d;
    logic              halt_q, halt_d;

    logic              req;
    logic              hit;
    logic [WORD_W-1:0] ld_sel;
    logic [WORD_W-1:0] sel_dat;

    // A completed access parked in HELD must not be re-issued while the pipe is frozen.
    always_comb begin
        req                = nRST && (state_q != HELD) && (m_dREN || m_dWEN) && !m_halt;
        hit                = req && dcache.dhit;
        dcache.dmemREN     = req && m_dREN && !m_dWEN;
        dcache.dmemWEN     = req && m_dWEN;
        dcache.dmemaddr    = req ? m_port_o   : '0;
        dcache.dmemstore   = req ? m_memstore : '0;
        mem_stall          = req && !dcache.dhit;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCESS: begin
                if (!req)                         state_d = IDLE;
                else if (!dcache.dhit)            state_d = ACCESS;
                else if (mw_state == PIPE_ENABLE) state_d = IDLE;
                else                              state_d = HELD;
            end
            HELD: begin
                if (mw_state == PIPE_ENABLE)      state_d = IDLE;
            end
            default:                              state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_d   = hit ? dcache.dmemload : ld_q;
        ld_sel = (state_q == HELD) ? ld_q : dcache.dmemload;
        case (m_MemToReg)
            2'd0:    sel_dat = m_port_o;
            2'd1:    sel_dat = ld_sel;
            2'd2:    sel_dat = m_pc4;
            default: sel_dat = m_lui;
        endcase
        m_fwd_dat = sel_dat;
    end

    // Memory-writeback latch; encoding 3 behaves as a stall.
    always_comb begin
        w_regwrite_d = w_regwrite_q;
        w_regwsel_d  = w_regwsel_q;
        w_wdat_d     = w_wdat_q;
        w_halt_d     = w_halt_q;
        case (mw_state)
            PIPE_ENABLE: begin
                w_regwrite_d = m_RegWrite;
                w_regwsel_d  = m_regWSEL;
                w_wdat_d     = sel_dat;
                w_halt_d     = m_halt;
            end
            PIPE_NOP: begin
                w_regwrite_d = 1'b0;
                w_regwsel_d  = '0;
                w_wdat_d     = '0;
                w_halt_d     = 1'b0;
            end
            PIPE_STALL: begin
                w_regwrite_d = w_regwrite_q;
            end
            default: begin
                w_regwrite_d = w_regwrite_q;
            end
        endcase
        halt_d = halt_q || w_halt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            ld_q         <= '0;
            w_regwrite_q <= 1'b0;
            w_regwsel_q  <= '0;
            w_wdat_q     <= '0;
            w_halt_q     <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_q         <= ld_d;
            w_regwrite_q <= w_regwrite_d;
            w_regwsel_q  <= w_regwsel_d;
            w_wdat_q     <= w_wdat_d;
            w_halt_q     <= w_halt_d;
            halt_q       <= halt_d;
        end
    end

    assign w_RegWrite = w_regwrite_q;
    assign w_regWSEL  = w_regwsel_q;
    assign w_wdat     = w_wdat_q;
    assign w_halt     = w_halt_q;
    assign halt       = halt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table for single-cycle instructions, hand sequences for
// misses, HELD behaviour, halt and asynchronous reset; writeback checked via a scoreboard.
module tb_memory_stage;

    localparam logic [1:0] ENA = 2'd0;
    localparam logic [1:0] STL = 2'd1;
    localparam logic [1:0] NOP = 2'd2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  mw_state;
    logic        m_dREN, m_dWEN, m_RegWrite, m_halt;
    logic [1:0]  m_MemToReg;
    logic [4:0]  m_regWSEL;
    logic [31:0] m_port_o, m_memstore, m_pc4, m_lui;
    logic        mem_stall;
    logic [31:0] m_fwd_dat;
    logic        w_RegWrite;
    logic [4:0]  w_regWSEL;
    logic [31:0] w_wdat;
    logic        w_halt, halt;

    memory_stage_if #(.WORD_W(32)) dc ();

    memory_stage #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .mw_state(mw_state),
        .m_dREN(m_dREN), .m_dWEN(m_dWEN), .m_RegWrite(m_RegWrite), .m_halt(m_halt),
        .m_MemToReg(m_MemToReg), .m_regWSEL(m_regWSEL),
        .m_port_o(m_port_o), .m_memstore(m_memstore), .m_pc4(m_pc4), .m_lui(m_lui),
        .dcache(dc),
        .mem_stall(mem_stall), .m_fwd_dat(m_fwd_dat),
        .w_RegWrite(w_RegWrite), .w_regWSEL(w_regWSEL), .w_wdat(w_wdat),
        .w_halt(w_halt), .halt(halt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen, rw;
        logic [1:0]  m2r;
        logic [4:0]  sel;
        logic [31:0] port, store, pc4, lui;
        logic        dhit;
        logic [31:0] load;
        logic        e_ren, e_wen, e_stall;
        logic [31:0] e_fwd;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  sel;
        logic [31:0] wdat;
        logic        hlt;
    } wb_t;

    vec_t vecs[7];
    wb_t  sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic rw, input logic [4:0] sel, input logic [31:0] wdat,
                           input logic hlt);
        wb_t e;
        e.rw = rw; e.sel = sel; e.wdat = wdat; e.hlt = hlt;
        sb.push_back(e);
    endtask

    // Advance one clock; retire any pending writeback expectation.
    task automatic step();
        wb_t e;
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk1("wb_regwrite", w_RegWrite, e.rw);
            chk32("wb_regwsel", {27'd0, w_regWSEL}, {27'd0, e.sel});
            chk32("wb_wdat", w_wdat, e.wdat);
            chk1("wb_halt", w_halt, e.hlt);
        end
    endtask

    task automatic clear_in();
        mw_state = ENA;
        m_dREN = 1'b0; m_dWEN = 1'b0; m_RegWrite = 1'b0; m_halt = 1'b0;
        m_MemToReg = 2'd0; m_regWSEL = 5'd0;
        m_port_o = 32'd0; m_memstore = 32'd0; m_pc4 = 32'd0; m_lui = 32'd0;
        dc.dhit = 1'b0; dc.dmemload = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ren_cnt;
        int stall_cnt;
        int wen_cnt;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 2'd0, 5'd5,  32'h0000_1234, 32'h0, 32'h4,     32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_1234};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 5'd8,  32'h0000_0100, 32'h0, 32'h0,     32'h0,         1'b1, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 32'h1111_2222};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 5'd31, 32'h0000_0010, 32'h0, 32'h404,   32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0404};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd3, 5'd9,  32'h0000_0020, 32'h0, 32'h0,     32'hABCD_0000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hABCD_0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 5'd6,  32'h0000_0200, 32'hCAFE, 32'h0,  32'h0,         1'b1, 32'h7777,      1'b0, 1'b1, 1'b0, 32'h0000_0200};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 2'd0, 5'd6,  32'h0000_0204, 32'hBEEF, 32'h0,  32'h0,         1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0204};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd0, 5'd11, 32'h0000_0055, 32'h0, 32'h0,     32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0055};

        // Reset: request outputs forced low even with a load presented.
        clear_in();
        nRST = 1'b0;
        m_dREN = 1'b1; m_port_o = 32'h0000_0300;
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_dmemREN", dc.dmemREN, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk32("rst_dmemaddr", dc.dmemaddr, 32'h0);
        chk1("rst_w_RegWrite", w_RegWrite, 1'b0);
        chk32("rst_w_wdat", w_wdat, 32'h0);
        chk1("rst_halt", halt, 1'b0);
        clear_in();
        nRST = 1'b1;

        for (int i = 0; i < 7; i++) begin
            mw_state = ENA;
            m_dREN = vecs[i].ren; m_dWEN = vecs[i].wen; m_RegWrite = vecs[i].rw;
            m_halt = 1'b0; m_MemToReg = vecs[i].m2r; m_regWSEL = vecs[i].sel;
            m_port_o = vecs[i].port; m_memstore = vecs[i].store;
            m_pc4 = vecs[i].pc4; m_lui = vecs[i].lui;
            dc.dhit = vecs[i].dhit; dc.dmemload = vecs[i].load;
            #1;
            chk1("vec_dmemREN", dc.dmemREN, vecs[i].e_ren);
            chk1("vec_dmemWEN", dc.dmemWEN, vecs[i].e_wen);
            chk1("vec_stall", mem_stall, vecs[i].e_stall);
            chk32("vec_fwd", m_fwd_dat, vecs[i].e_fwd);
            chk32("vec_dmemaddr", dc.dmemaddr,
                  (vecs[i].e_ren || vecs[i].e_wen) ? vecs[i].port : 32'h0);
            chk32("vec_dmemstore", dc.dmemstore,
                  (vecs[i].e_ren || vecs[i].e_wen) ? vecs[i].store : 32'h0);
            push_wb(vecs[i].rw, vecs[i].sel, vecs[i].e_fwd, 1'b0);
            step();
        end

        // Load miss: dhit on the fourth cycle.
        clear_in();
        m_dREN = 1'b1; m_MemToReg = 2'd1; m_RegWrite = 1'b1; m_regWSEL = 5'd10;
        m_port_o = 32'h0000_0100;
        ren_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            dc.dhit = (c == 3);
            dc.dmemload = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            mw_state = (c == 3) ? ENA : STL;
            #1;
            ren_cnt += int'(dc.dmemREN);
            stall_cnt += int'(mem_stall);
            chk32("miss_addr", dc.dmemaddr, 32'h0000_0100);
            if (c == 3) begin
                chk32("miss_fwd", m_fwd_dat, 32'hDEAD_BEEF);
                push_wb(1'b1, 5'd10, 32'hDEAD_BEEF, 1'b0);
            end
            step();
        end
        chk32("miss_ren_cycles", 32'(ren_cnt), 32'd4);
        chk32("miss_stall_cycles", 32'(stall_cnt), 32'd3);

        // Store hits while MW is stalled: no re-issue while held.
        clear_in();
        m_dWEN = 1'b1; m_port_o = 32'h0000_0200; m_memstore = 32'h0000_CAFE; m_regWSEL = 5'd3;
        wen_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            dc.dhit = (c == 0);
            mw_state = (c == 3) ? ENA : STL;
            #1;
            wen_cnt += int'(dc.dmemWEN);
            stall_cnt += int'(mem_stall);
            if (c == 0) chk32("held_store_data", dc.dmemstore, 32'h0000_CAFE);
            if (c == 3) push_wb(1'b0, 5'd3, 32'h0000_0200, 1'b0);
            step();
        end
        chk32("held_wen_cycles", 32'(wen_cnt), 32'd1);
        chk32("held_stall_cycles", 32'(stall_cnt), 32'd0);
        dc.dhit = 1'b0; mw_state = STL;
        #1;
        chk1("after_held_reissue", dc.dmemWEN, 1'b1);
        chk1("after_held_stall", mem_stall, 1'b1);
        step();
        dc.dhit = 1'b1; mw_state = ENA;
        #1;
        chk1("after_held_hit_stall", mem_stall, 1'b0);
        push_wb(1'b0, 5'd3, 32'h0000_0200, 1'b0);
        step();

        // Load hit during stall; cache data later changes but captured value is used.
        clear_in();
        m_dREN = 1'b1; m_MemToReg = 2'd1; m_RegWrite = 1'b1; m_regWSEL = 5'd12;
        m_port_o = 32'h0000_0300;
        dc.dhit = 1'b1; dc.dmemload = 32'h5A5A_1234; mw_state = STL;
        #1;
        chk32("cap_fwd_hit", m_fwd_dat, 32'h5A5A_1234);
        step();
        dc.dhit = 1'b0; dc.dmemload = 32'h0;
        #1;
        chk1("cap_no_reissue", dc.dmemREN, 1'b0);
        chk32("cap_fwd_held", m_fwd_dat, 32'h5A5A_1234);
        step();
        mw_state = ENA;
        #1;
        push_wb(1'b1, 5'd12, 32'h5A5A_1234, 1'b0);
        step();

        // NOP clears the latch; STALL holds it.
        clear_in();
        m_RegWrite = 1'b1; m_regWSEL = 5'd7; m_port_o = 32'h0000_0077; mw_state = NOP;
        #1;
        push_wb(1'b0, 5'd0, 32'h0, 1'b0);
        step();
        mw_state = ENA;
        push_wb(1'b1, 5'd7, 32'h0000_0077, 1'b0);
        step();
        mw_state = STL; m_port_o = 32'h0000_0099; m_regWSEL = 5'd1;
        step();
        chk32("stall_hold_wdat", w_wdat, 32'h0000_0077);
        chk1("stall_hold_rw", w_RegWrite, 1'b1);

        // Halt instruction: no request, w_halt then sticky halt.
        clear_in();
        m_halt = 1'b1; m_dREN = 1'b1; m_port_o = 32'h0000_0400;
        #1;
        chk1("halt_no_req", dc.dmemREN, 1'b0);
        chk1("halt_no_stall", mem_stall, 1'b0);
        push_wb(1'b0, 5'd0, 32'h0000_0400, 1'b1);
        step();
        chk1("halt_not_yet", halt, 1'b0);
        clear_in();
        for (int c = 0; c < 4; c++) begin
            push_wb(1'b0, 5'd0, 32'h0, 1'b0);
            step();
            chk1("halt_sticky", halt, 1'b1);
        end

        // Reset during an outstanding load.
        clear_in();
        m_RegWrite = 1'b1; m_regWSEL = 5'd2; m_port_o = 32'h0000_9999;
        push_wb(1'b1, 5'd2, 32'h0000_9999, 1'b0);
        step();
        clear_in();
        m_dREN = 1'b1; m_MemToReg = 2'd1; m_port_o = 32'h0000_0500; mw_state = STL;
        #1;
        chk1("rmid_req_before", dc.dmemREN, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        chk1("rmid_dmemREN", dc.dmemREN, 1'b0);
        chk1("rmid_stall", mem_stall, 1'b0);
        chk32("rmid_addr", dc.dmemaddr, 32'h0);
        chk1("rmid_w_RegWrite", w_RegWrite, 1'b0);
        chk32("rmid_w_wdat", w_wdat, 32'h0);
        chk1("rmid_halt", halt, 1'b0);
        @(posedge CLK);
        #1;
        clear_in();
        nRST = 1'b1;
        m_RegWrite = 1'b1; m_regWSEL = 5'd4; m_port_o = 32'h0000_1234;
        #1;
        chk1("post_rst_stall", mem_stall, 1'b0);
        push_wb(1'b1, 5'd4, 32'h0000_1234, 1'b0);
        step();
        chk1("post_rst_halt", halt, 1'b0);
        chk32("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage pipelined MIPS datapath. Consumes the execute-memory latch outputs, issues data-cache read/write requests and holds them until `dhit`, and selects the writeback value. Owns the memory-writeback latch feeding register-file writeback and the sticky halt. Raises `mem_stall` to the hazard unit while a data access is outstanding.

## Interface
Parameters:
- `WORD_W`, 32, datapath word width
- `REG_W`, 5, register select width

Ports:
- `CLK`  in  1  system clock, all state on rising edge
- `nRST`  in  1  asynchronous active-low reset
- `mw_state`  in  2  pipe_state_t for the memory-writeback latch: PIPE_ENABLE=0 (load), PIPE_STALL=1 (hold), PIPE_NOP=2 (clear)
- `m_dREN`, `m_dWEN`  in  1 each  load / store request from the execute-memory latch
- `m_RegWrite`, `m_halt`  in  1 each  carried control
- `m_MemToReg`  in  2  writeback select: 0 = `m_port_o`, 1 = load data, 2 = `m_pc4`, 3 = `m_lui`
- `m_regWSEL`  in  REG_W  destination register
- `m_port_o`, `m_memstore`, `m_pc4`, `m_lui`  in  WORD_W each  ALU result/address, store data, PC+4, LUI value
- `dhit`  in  1  data cache access complete this cycle
- `dmemload`  in  WORD_W  cache read data, valid when `dhit`
- `dmemREN`, `dmemWEN`  out  1 each  cache request
- `dmemaddr`, `dmemstore`  out  WORD_W each  cache address / store data
- `mem_stall`  out  1  access outstanding; freeze pipeline
- `m_fwd_dat`  out  WORD_W  memory-stage result for forwarding (combinational)
- `w_RegWrite`  out  1  registered
- `w_regWSEL`  out  REG_W  registered
- `w_wdat`  out  WORD_W  registered writeback data
- `w_halt`  out  1  registered halt carried to writeback
- `halt`  out  1  sticky halt to the system

## Operation
- Access FSM, states IDLE, ACCESS, HELD. Reset to IDLE.
- IDLE: a fresh instruction sits in the latch. If `m_dREN|m_dWEN` and not `m_halt`, request issues combinationally this cycle (FSM is in ACCESS semantics immediately; state register moves to ACCESS unless `dhit` the same cycle).
- ACCESS: `dmemREN=m_dREN`, `dmemWEN=m_dWEN`, `dmemaddr=m_port_o`, `dmemstore=m_memstore`; held stable until `dhit`. `mem_stall = request & !dhit`.
- On `dhit`: load data captured into internal `ld_q`. If `mw_state==PIPE_ENABLE` the instruction leaves; next state IDLE. Otherwise next state HELD.
- HELD: no request (`dmemREN=dmemWEN=0`), `mem_stall=0`, load data taken from `ld_q`. Leave to IDLE when `mw_state==PIPE_ENABLE`. Prevents re-issuing a completed access while the pipeline is frozen for another reason.
- `dREN` and `dWEN` both set: treated as illegal; store takes priority, `dmemREN` forced 0.
- Load data mux: `dhit` cycle uses `dmemload`; HELD uses `ld_q`.
- `m_fwd_dat` = MemToReg-selected value (load data source per above).
- MW latch: PIPE_ENABLE loads `m_RegWrite`, `m_regWSEL`, selected data, `m_halt`; PIPE_STALL holds; PIPE_NOP clears all to 0. Value 3 treated as PIPE_STALL.
- `halt` sets when `w_halt` is 1; cleared only by reset.

## Timing
- Reset: all registered outputs 0, `ld_q=0`, state IDLE, `halt=0`; combinational request outputs 0 while `nRST` low.
- Non-memory instruction: zero stall; `w_*` valid one cycle after entering memory stage.
- Load with cache hit in first cycle: zero stall, `w_wdat=dmemload` next edge.
- Miss of N cycles: `mem_stall` high exactly N cycles, drops in the `dhit` cycle.
- `nRST` asserted mid-access: request deasserts immediately, FSM IDLE; no partial writeback.
- `dhit` while not requesting: ignored.

## Test plan
- Reset, then ALU op `m_port_o=0x0000_1234`, MemToReg=0, RegWrite=1, regWSEL=5, ENABLE -> next edge `w_wdat=0x1234`, `w_regWSEL=5`, `mem_stall` never high.
- Load addr 0x100, `dhit` after 3 cycles with `dmemload=0xDEADBEEF` -> `dmemREN` 4 cycles, `mem_stall` 3 cycles, `w_wdat=0xDEADBEEF`.
- Store addr 0x200 data 0xCAFE, `dhit` same cycle as `mw_state=PIPE_STALL` for 2 more cycles -> `dmemWEN` drops after hit, no re-issue in HELD, stall 0.
- Load hits while `mw_state=PIPE_STALL`, `dmemload` then changes to 0x0 -> on ENABLE `w_wdat` equals captured value.
- PIPE_NOP with valid inputs -> `w_RegWrite=0`, `w_wdat=0`; halt instruction then ENABLE -> `w_halt=1`, `halt=1` one edge later and stays set until `nRST`.
- `nRST` low during outstanding load -> `dmemREN=0` immediately, all outputs 0, FSM IDLE.
